// File: rtl/tx_data_control_p_if.sv
// rtl/tx_data_control_p_if.sv - character offer/accept handshake into the DS encoder
//
// Purpose: carries one character from the TX FSM/credit logic to the encoder.
// Ports (signals):
//   char_valid  master->slave  character offered
//   char_type   master->slave  0 data, 1 control, 2 time code, 3 reserved (control)
//   char_data   master->slave  data/time-code byte, control code in [1:0]
//   char_ready  slave->master  encoder takes the offered char this cycle
interface tx_data_control_p_if;
    logic       char_valid;
    logic [1:0] char_type;
    logic [7:0] char_data;
    logic       char_ready;

    modport master (
        output char_valid,
        output char_type,
        output char_data,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_type,
        input  char_data,
        output char_ready
    );
endinterface

// File: rtl/tx_data_control_p.sv
// rtl/tx_data_control_p.sv - SpaceWire transmit character encoder onto Data/Strobe lines
//
// Purpose: serialises data, control, time-code and auto-NULL characters, one bit per
// clock, with odd parity and DS strobe encoding.
// Ports:
//   posedge_clk  in   transmit clock (rising edge)
//   tx_reset     in   asynchronous active-high reset
//   enable_tx    in   1: transmitter enabled, 0: lines low and encoder flushed
//   ch           slave character handshake (char_valid/type/data in, char_ready out)
//   dout, sout   out  registered DS data and strobe lines
//   busy         out  dout currently carries a bit of a character
module tx_data_control_p #(
    parameter bit PAR_INIT    = 1'b0,
    parameter bit INSERT_NULL = 1'b1
) (
    input  logic                      posedge_clk,
    input  logic                      tx_reset,
    input  logic                      enable_tx,
    tx_data_control_p_if.slave        ch,
    output logic                      dout,
    output logic                      sout,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    state_t      state;
    logic [12:0] shreg;
    logic [3:0]  bit_cnt;
    logic        prev_par;
    logic        pend_par;

    logic [13:0] ld_vec;
    logic [3:0]  ld_len;
    logic        ld_par;
    logic        start_char;
    logic        emit_bit;

    // LOAD is entered in the cycle the last bit of the previous char sits on dout,
    // so accepting here gives back-to-back characters with no idle bit.
    assign ch.char_ready = (state == ST_LOAD) && enable_tx;
    assign start_char    = ch.char_valid || INSERT_NULL;
    assign emit_bit      = (state == ST_LOAD) ? ld_vec[0] : shreg[0];

    // Whole character sequence, first bit in bit 0. Control P = ~(1 ^ prev_par) = prev_par,
    // data P = ~prev_par. Inside NULL / time code the char following the ESC sees a
    // previous payload of 2'b11, whose parity is 0, so its P is fixed.
    always_comb begin
        ld_vec = '0;
        ld_len = 4'd8;
        ld_par = 1'b0;
        if (!ch.char_valid) begin
            ld_vec[7:0] = {4'b0010, 3'b111, prev_par};
        end else begin
            case (ch.char_type)
                2'd0: begin
                    ld_vec[9:0] = {ch.char_data, 1'b0, ~prev_par};
                    ld_len      = 4'd10;
                    ld_par      = ^ch.char_data;
                end
                2'd2: begin
                    ld_vec = {ch.char_data, 1'b0, 1'b1, 3'b111, prev_par};
                    ld_len = 4'd14;
                    ld_par = ^ch.char_data;
                end
                default: begin
                    ld_vec[3:0] = {ch.char_data[1:0], 1'b1, prev_par};
                    ld_len      = 4'd4;
                    ld_par      = ^ch.char_data[1:0];
                end
            endcase
        end
    end

    always_ff @(posedge posedge_clk or posedge tx_reset) begin
        if (tx_reset) begin
            state    <= ST_OFF;
            shreg    <= '0;
            bit_cnt  <= '0;
            prev_par <= PAR_INIT;
            pend_par <= PAR_INIT;
            dout     <= 1'b0;
            sout     <= 1'b0;
            busy     <= 1'b0;
        end else if (!enable_tx) begin
            state    <= ST_OFF;
            shreg    <= '0;
            bit_cnt  <= '0;
            prev_par <= PAR_INIT;
            pend_par <= PAR_INIT;
            dout     <= 1'b0;
            sout     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    state <= ST_LOAD;
                    busy  <= 1'b0;
                end
                ST_LOAD: begin
                    if (start_char) begin
                        dout     <= emit_bit;
                        // strobe flips when data does not, so dout^sout changes every bit
                        sout     <= sout ^ (emit_bit ~^ dout);
                        shreg    <= ld_vec[13:1];
                        bit_cnt  <= ld_len - 4'd1;
                        pend_par <= ld_par;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    dout    <= emit_bit;
                    sout    <= sout ^ (emit_bit ~^ dout);
                    shreg   <= {1'b0, shreg[12:1]};
                    bit_cnt <= bit_cnt - 4'd1;
                    busy    <= 1'b1;
                    if (bit_cnt == 4'd1) begin
                        // last bit goes out now; its payload parity becomes visible to the next P
                        state    <= ST_LOAD;
                        prev_par <= pend_par;
                    end
                end
                default: begin
                    state <= ST_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_data_control_p.sv
// tb/tb_tx_data_control_p.sv - self-checking bench for tx_data_control_p
module tb_tx_data_control_p;

    logic       clk = 1'b0;
    logic       tx_reset;
    logic       enable_tx;
    logic       c_valid;
    logic [1:0] c_type;
    logic [7:0] c_data;
    logic       dout_a, sout_a, busy_a;
    logic       dout_b, sout_b, busy_b;

    tx_data_control_p_if ch_a ();
    tx_data_control_p_if ch_b ();

    assign ch_a.char_valid = c_valid;
    assign ch_a.char_type  = c_type;
    assign ch_a.char_data  = c_data;
    assign ch_b.char_valid = c_valid;
    assign ch_b.char_type  = c_type;
    assign ch_b.char_data  = c_data;

    always #5 clk = ~clk;

    tx_data_control_p #(.PAR_INIT(1'b0), .INSERT_NULL(1'b1)) dut_a (
        .posedge_clk (clk),
        .tx_reset    (tx_reset),
        .enable_tx   (enable_tx),
        .ch          (ch_a),
        .dout        (dout_a),
        .sout        (sout_a),
        .busy        (busy_a)
    );

    tx_data_control_p #(.PAR_INIT(1'b1), .INSERT_NULL(1'b0)) dut_b (
        .posedge_clk (clk),
        .tx_reset    (tx_reset),
        .enable_tx   (enable_tx),
        .ch          (ch_b),
        .dout        (dout_b),
        .sout        (sout_b),
        .busy        (busy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    // ---------------- behavioural model: one bit queue per encoder ----------------
    bit m_on   [2];
    bit m_pp   [2];
    bit m_dout [2];
    bit m_sout [2];
    bit m_busy [2];
    bit prev_x [2];
    bit mq     [2][$];
    bit par_init [2] = '{1'b0, 1'b1};
    bit ins_null [2] = '{1'b1, 1'b0};

    // character = P, flag, payload bits; P gives odd parity over prev payload, P and flag
    task automatic m_push(input int i, input bit flag, input bit [7:0] pl, input int n);
        bit x;
        x = 1'b0;
        mq[i].push_back(~(flag ^ m_pp[i]));
        mq[i].push_back(flag);
        for (int k = 0; k < n; k++) begin
            mq[i].push_back(pl[k]);
            x = x ^ pl[k];
        end
        m_pp[i] = x;
    endtask

    task automatic m_clear(input int i);
        m_on[i]   = 1'b0;
        m_pp[i]   = par_init[i];
        m_dout[i] = 1'b0;
        m_sout[i] = 1'b0;
        m_busy[i] = 1'b0;
        mq[i].delete();
    endtask

    // independent receiver-side parity checker on encoder A's line
    bit rx_bits[$];
    bit rx_pp;
    bit in_stream = 1'b0;
    int gap_cnt   = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic d, s, b, r, x, want_x, want_r, par_ok, nx, bb;
            d = (i == 0) ? dout_a : dout_b;
            s = (i == 0) ? sout_a : sout_b;
            b = (i == 0) ? busy_a : busy_b;
            r = (i == 0) ? ch_a.char_ready : ch_b.char_ready;
            if (tx_reset) m_clear(i);
            want_r = m_on[i] && (mq[i].size() == 0) && enable_tx;
            chk($sformatf("dout%0d", i), d, m_dout[i]);
            chk($sformatf("sout%0d", i), s, m_sout[i]);
            chk($sformatf("busy%0d", i), b, m_busy[i]);
            chk($sformatf("ready%0d", i), r, want_r);
            x = d ^ s;
            if (m_busy[i]) begin
                want_x = ~prev_x[i];
                chk($sformatf("ds_toggle%0d", i), x, want_x);
            end
            prev_x[i] = x;

            if (i == 0) begin
                if (in_stream && !b) gap_cnt++;
                if (tx_reset || !m_on[0]) begin
                    rx_bits.delete();
                    rx_pp = par_init[0];
                end else if (m_busy[0]) begin
                    rx_bits.push_back(d);
                    if (rx_bits.size() >= 2 && rx_bits.size() == (rx_bits[1] ? 4 : 10)) begin
                        par_ok = rx_bits[0] ^ rx_bits[1] ^ rx_pp;
                        chk("rx_parity", par_ok, 1);
                        rx_pp = 1'b0;
                        for (int k = 2; k < rx_bits.size(); k++) rx_pp = rx_pp ^ rx_bits[k];
                        rx_bits.delete();
                    end
                end
            end

            if (!tx_reset) begin
                if (!enable_tx) begin
                    m_clear(i);
                end else if (!m_on[i]) begin
                    m_on[i]   = 1'b1;
                    m_busy[i] = 1'b0;
                end else begin
                    if (mq[i].size() == 0) begin
                        if (c_valid) begin
                            case (c_type)
                                2'd0: m_push(i, 1'b0, c_data, 8);
                                2'd2: begin
                                    m_push(i, 1'b1, 8'h03, 2);
                                    m_push(i, 1'b0, c_data, 8);
                                end
                                default: m_push(i, 1'b1, c_data, 2);
                            endcase
                        end else if (ins_null[i]) begin
                            m_push(i, 1'b1, 8'h03, 2);
                            m_push(i, 1'b1, 8'h00, 2);
                        end
                    end
                    if (mq[i].size() != 0) begin
                        bb = mq[i].pop_front();
                        nx = ~(m_dout[i] ^ m_sout[i]);
                        m_dout[i] = bb;
                        m_sout[i] = bb ^ nx;
                        m_busy[i] = 1'b1;
                    end else begin
                        m_busy[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_char(input logic [1:0] t, input logic [7:0] d);
        int n;
        n       = 0;
        c_valid = 1'b1;
        c_type  = t;
        c_data  = d;
        #1;
        while (ch_a.char_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("handshake", ch_a.char_ready, 1);
        @(posedge clk);
        #1;
        c_valid = 1'b0;
    endtask

    // first bit is the MSB of the n-bit literal; called with the first bit on dout
    task automatic expect_seq(input logic [31:0] v, input int n, input string nm);
        logic [31:0] got;
        got = '0;
        for (int k = 0; k < n; k++) begin
            got[n-1-k] = dout_a;
            if (k < n - 1) begin
                @(posedge clk);
                #1;
            end
        end
        chk(nm, got, v);
    endtask

    initial begin
        int tog;
        logic last_s;
        tx_reset  = 1'b1;
        enable_tx = 1'b0;
        c_valid   = 1'b0;
        c_type    = 2'd0;
        c_data    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout_a", dout_a, 0);
        chk("rst_sout_a", sout_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_ready_a", ch_a.char_ready, 0);
        chk("rst_ready_b", ch_b.char_ready, 0);

        tx_reset  = 1'b0;
        enable_tx = 1'b1;
        @(posedge clk);
        #1;
        chk("load_dout", dout_a, 0);
        chk("load_ready", ch_a.char_ready, 1);
        @(posedge clk);
        #1;
        expect_seq(32'b0111_0100_0111_0100, 16, "null_x2");
        send_char(2'd0, 8'h55);
        expect_seq(32'b10_1010_1010, 10, "data_55");
        send_char(2'd2, 8'h3F);
        expect_seq(32'b01_1110_1111_1100, 14, "tcode_3f");

        in_stream = 1'b1;
        gap_cnt   = 0;
        for (int k = 0; k < 60; k++) begin
            int sel;
            sel = $urandom_range(0, 6);
            case (sel)
                0, 1:    send_char(2'd0, 8'($urandom));
                2:       send_char(2'd1, {6'($urandom), 2'd0});
                3:       send_char(2'd1, {6'($urandom), 2'd1});
                4:       send_char(2'd1, {6'($urandom), 2'd2});
                5:       send_char(2'd3, 8'($urandom));
                default: send_char(2'd2, 8'($urandom));
            endcase
        end
        in_stream = 1'b0;
        chk("stream_gap", gap_cnt, 0);

        send_char(2'd1, 8'h01);
        send_char(2'd0, 8'hA7);
        repeat (5) @(posedge clk);
        #1;
        enable_tx = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_dout", dout_a, 0);
        chk("dis_sout", sout_a, 0);
        chk("dis_busy", busy_a, 0);
        enable_tx = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        expect_seq(32'b0111_0100, 8, "null_reenable");

        send_char(2'd2, 8'hC3);
        repeat (4) @(posedge clk);
        #3;
        tx_reset = 1'b1;
        #1;
        chk("async_dout_a", dout_a, 0);
        chk("async_sout_a", sout_a, 0);
        chk("async_busy_a", busy_a, 0);
        chk("async_dout_b", dout_b, 0);
        @(posedge clk);
        #1;
        tx_reset = 1'b0;
        c_valid  = 1'b0;
        tog      = 0;
        last_s   = sout_b;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (sout_b !== last_s) tog++;
            last_s = sout_b;
        end
        chk("idle_hold_toggles", tog, 0);
        chk("idle_hold_dout", dout_b, 0);

        repeat (500) begin
            @(posedge clk);
            #1;
            c_valid   = ($urandom_range(0, 3) != 0);
            c_type    = 2'($urandom);
            c_data    = 8'($urandom);
            enable_tx = ($urandom_range(0, 40) != 0);
            tx_reset  = ($urandom_range(0, 150) == 0);
        end
        @(posedge clk);
        #1;
        tx_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
